// File: rtl/gfx_pkg.sv
// Shared graphics constants and swap-controller state encoding.
package gfx_pkg;
  localparam int FB_WIDTH_DEF  = 400;
  localparam int FB_HEIGHT_DEF = 240;
  localparam int COLOR_W       = 16;

  typedef enum logic {
    SWAP_IDLE        = 1'b0,
    SWAP_WAIT_VBLANK = 1'b1
  } swap_state_e;
endpackage

// File: rtl/fb_bram.sv
// One framebuffer bank: simple dual-port RAM with a registered read port.
module fb_bram
  import gfx_pkg::*;
#(
  parameter int DEPTH = FB_WIDTH_DEF * FB_HEIGHT_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [COLOR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [COLOR_W-1:0] rdata_o
);

  logic [COLOR_W-1:0] mem_q [DEPTH];
  logic [COLOR_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/framebuffer.sv
// Double-buffered framebuffer: GPU writes the back bank, display scans the
// front bank, and a swap request is honoured at the next vblank rising edge.
module framebuffer
  import gfx_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(FB_WIDTH)+1-1:0]  fb_x,
  input  logic [$clog2(FB_HEIGHT)+1-1:0] fb_y,
  input  logic [COLOR_W-1:0]             fb_color,
  input  logic                           fb_write,
  input  logic                           swap_req,
  input  logic                           vblank,
  input  logic                           scan_en,
  input  logic [$clog2(FB_WIDTH)+1-1:0]  scan_x,
  input  logic [$clog2(FB_HEIGHT)+1-1:0] scan_y,
  output logic [COLOR_W-1:0]             scan_color,
  output logic                           scan_valid,
  output logic                           front_sel,
  output logic                           swap_pending,
  output logic                           swap_done
);

  localparam int XW    = $clog2(FB_WIDTH) + 1;
  localparam int YW    = $clog2(FB_HEIGHT) + 1;
  localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [XW-1:0] X_LIM = XW'(FB_WIDTH);
  localparam logic [YW-1:0] Y_LIM = YW'(FB_HEIGHT);

  // Constant-width multiply; synthesis folds it into shifts and adds.
  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x,
                                             input logic [YW-1:0] y);
    return AW'(32'(y) * 32'(FB_WIDTH) + 32'(x));
  endfunction

  swap_state_e state_q, state_d;
  logic        front_sel_q;
  logic        swap_done_q;
  logic        swap_req_q, vblank_q;
  logic        toggle;
  logic        req_rise, vb_rise;

  logic          wr_in_range, rd_in_range;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          we0, we1, re0, re1;
  logic [COLOR_W-1:0] rd0, rd1;
  logic          scan_valid_q, zero_q, rsel_q;

  assign req_rise = !swap_req_q && swap_req;
  assign vb_rise  = !vblank_q && vblank;

  always_comb begin
    state_d = state_q;
    toggle  = 1'b0;
    case (state_q)
      SWAP_IDLE: begin
        if (req_rise) state_d = SWAP_WAIT_VBLANK;
      end
      SWAP_WAIT_VBLANK: begin
        if (vb_rise) begin
          toggle  = 1'b1;
          state_d = SWAP_IDLE;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SWAP_IDLE;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      swap_req_q  <= 1'b0;
      vblank_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_q ^ toggle;
      swap_done_q <= toggle;
      swap_req_q  <= swap_req;
      vblank_q    <= vblank;
    end
  end

  assign wr_in_range = (fb_x < X_LIM) && (fb_y < Y_LIM);
  assign rd_in_range = (scan_x < X_LIM) && (scan_y < Y_LIM);
  assign wr_addr     = pix_addr(fb_x, fb_y);
  assign rd_addr     = pix_addr(scan_x, scan_y);

  // Bank steering uses the registered select, so a toggle-cycle access
  // still sees the pre-swap bank roles.
  assign we0 = fb_write && wr_in_range && !reset && front_sel_q;
  assign we1 = fb_write && wr_in_range && !reset && !front_sel_q;
  assign re0 = scan_en && rd_in_range && !front_sel_q;
  assign re1 = scan_en && rd_in_range && front_sel_q;

  fb_bram #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk_i(clk), .we_i(we0), .waddr_i(wr_addr), .wdata_i(fb_color),
    .re_i(re0), .raddr_i(rd_addr), .rdata_o(rd0)
  );

  fb_bram #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk_i(clk), .we_i(we1), .waddr_i(wr_addr), .wdata_i(fb_color),
    .re_i(re1), .raddr_i(rd_addr), .rdata_o(rd1)
  );

  // zero_q forces the output to 0 after reset and for out-of-range reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_valid_q <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      scan_valid_q <= scan_en;
      if (scan_en) zero_q <= !rd_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (scan_en) rsel_q <= front_sel_q;
  end

  assign scan_color   = zero_q ? '0 : (rsel_q ? rd1 : rd0);
  assign scan_valid   = scan_valid_q;
  assign front_sel    = front_sel_q;
  assign swap_pending = (state_q == SWAP_WAIT_VBLANK);
  assign swap_done    = swap_done_q;

endmodule

// File: tb/tb_framebuffer.sv
// Directed testbench for the double-buffered framebuffer (reduced geometry).
module tb_framebuffer;
  localparam int W  = 24;
  localparam int H  = 24;
  localparam int N  = W * H;
  localparam int XW = $clog2(W) + 1;
  localparam int YW = $clog2(H) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [XW-1:0] fb_x, scan_x;
  logic [YW-1:0] fb_y, scan_y;
  logic [15:0]   fb_color;
  logic          fb_write, swap_req, vblank, scan_en;
  logic [15:0]   scan_color;
  logic          scan_valid, front_sel, swap_pending, swap_done;

  int checks = 0;
  int errors = 0;
  logic        exp_front;
  logic [15:0] m0 [N];
  logic [15:0] m1 [N];

  framebuffer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk(clk), .reset(reset),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .swap_req(swap_req), .vblank(vblank),
    .scan_en(scan_en), .scan_x(scan_x), .scan_y(scan_y),
    .scan_color(scan_color), .scan_valid(scan_valid),
    .front_sel(front_sel), .swap_pending(swap_pending), .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] pat_a(input int i);
    return 16'(i * 37 + 4097);
  endfunction

  function automatic logic [15:0] pat_b(input int i);
    return 16'(i * 91) ^ 16'hF0F0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int x, input int y, input logic [15:0] c);
    fb_x = XW'(x); fb_y = YW'(y); fb_color = c; fb_write = 1'b1;
    if (x < W && y < H) begin
      if (exp_front) m0[y*W+x] = c;
      else           m1[y*W+x] = c;
    end
    tick();
    fb_write = 1'b0;
  endtask

  task automatic do_read(input int x, input int y);
    scan_x = XW'(x); scan_y = YW'(y); scan_en = 1'b1;
    tick();
    scan_en = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    vblank = 1'b1; tick();
    vblank = 1'b0; tick();
    exp_front = ~exp_front;
  endtask

  task automatic full_scan(input string name);
    logic [15:0] exp;
    scan_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      scan_x = XW'(i % W); scan_y = YW'(i / W);
      tick();
      exp = exp_front ? m1[i] : m0[i];
      checks++;
      if (scan_valid !== 1'b1 || scan_color !== exp) begin
        errors++;
        $display("FAIL %s pixel %0d: got valid=%b color=%h, expected valid=1 color=%h",
                 name, i, scan_valid, scan_color, exp);
      end
    end
    scan_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({front_sel, swap_pending, swap_done, scan_valid} !== 4'b0000 || scan_color !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got fs=%b pend=%b done=%b vld=%b color=%h, expected all 0",
               front_sel, swap_pending, swap_done, scan_valid, scan_color);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_write(10, 20, 16'hABCD);
    do_read(10, 20);
    checks++;
    if (scan_color !== 16'h0 || scan_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_front0_read: got color=%h vld=%b, expected 0000 1", scan_color, scan_valid);
    end
    swap_req = 1'b1; tick();
    checks++;
    if (swap_pending !== 1'b1) begin
      errors++;
      $display("FAIL basic_pending: got %b, expected 1", swap_pending);
    end
    swap_req = 1'b0; tick();
    vblank = 1'b1; tick();
    checks++;
    if (front_sel !== 1'b1 || swap_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_swap: got fs=%b done=%b, expected 1 1", front_sel, swap_done);
    end
    exp_front = 1'b1;
    vblank = 1'b0; tick();
    checks++;
    if (swap_done !== 1'b0 || swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b pend=%b, expected 0 0", swap_done, swap_pending);
    end
    do_read(10, 20);
    checks++;
    if (scan_color !== 16'hABCD || scan_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_readback: got color=%h vld=%b, expected abcd 1", scan_color, scan_valid);
    end
  endtask

  task automatic test_fill_scan();
    for (int i = 0; i < N; i++) do_write(i % W, i / W, pat_a(i));
    do_swap();
    full_scan("fill_scan_a");
    for (int i = 0; i < N; i++) do_write(i % W, i / W, pat_b(i));
  endtask

  task automatic test_out_of_range();
    do_write(W, 5, 16'h1111);
    do_write(5, H, 16'h2222);
    do_read(1, 1);
    tick();
    checks++;
    if (scan_valid !== 1'b0 || scan_color !== pat_a(W + 1)) begin
      errors++;
      $display("FAIL idle_hold: got vld=%b color=%h, expected 0 %h", scan_valid, scan_color, pat_a(W + 1));
    end
    do_read(W, 0);
    checks++;
    if (scan_color !== 16'h0 || scan_valid !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: got color=%h vld=%b, expected 0000 1", scan_color, scan_valid);
    end
    full_scan("oor_bank0");
    do_swap();
    full_scan("oor_bank1");
  endtask

  task automatic test_double_req();
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    checks++;
    if (swap_pending !== 1'b1 || front_sel !== 1'b1) begin
      errors++;
      $display("FAIL dbl_pending: got pend=%b fs=%b, expected 1 1", swap_pending, front_sel);
    end
    vblank = 1'b1; tick();
    checks++;
    if (front_sel !== 1'b0 || swap_done !== 1'b1) begin
      errors++;
      $display("FAIL dbl_first_vblank: got fs=%b done=%b, expected 0 1", front_sel, swap_done);
    end
    exp_front = 1'b0;
    vblank = 1'b0; tick();
    checks++;
    if (swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL dbl_no_queue: got pend=%b, expected 0", swap_pending);
    end
    vblank = 1'b1; tick();
    checks++;
    if (front_sel !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL dbl_second_vblank: got fs=%b done=%b, expected 0 0", front_sel, swap_done);
    end
    vblank = 1'b0; tick();
  endtask

  task automatic test_toggle_cycle();
    swap_req = 1'b1; tick();
    swap_req = 1'b0; tick();
    vblank = 1'b1;
    fb_x = XW'(3); fb_y = YW'(4); fb_color = 16'h1234; fb_write = 1'b1;
    scan_x = XW'(3); scan_y = YW'(4); scan_en = 1'b1;
    m1[4*W+3] = 16'h1234;
    tick();
    fb_write = 1'b0; scan_en = 1'b0; vblank = 1'b0;
    checks++;
    if (scan_color !== pat_a(4*W+3) || scan_valid !== 1'b1 || front_sel !== 1'b1) begin
      errors++;
      $display("FAIL toggle_read: got color=%h vld=%b fs=%b, expected %h 1 1",
               scan_color, scan_valid, front_sel, pat_a(4*W+3));
    end
    exp_front = 1'b1;
    tick();
    do_read(3, 4);
    checks++;
    if (scan_color !== 16'h1234) begin
      errors++;
      $display("FAIL toggle_write: got %h, expected 1234", scan_color);
    end
  endtask

  task automatic test_reset_pending();
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    checks++;
    if (swap_pending !== 1'b1) begin
      errors++;
      $display("FAIL rstp_pending: got %b, expected 1", swap_pending);
    end
    reset = 1'b1;
    fb_x = XW'(7); fb_y = YW'(7); fb_color = 16'hDEAD; fb_write = 1'b1;
    tick();
    reset = 1'b0; fb_write = 1'b0;
    exp_front = 1'b0;
    checks++;
    if (front_sel !== 1'b0 || swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL rstp_state: got fs=%b pend=%b, expected 0 0", front_sel, swap_pending);
    end
    vblank = 1'b1; tick();
    checks++;
    if (front_sel !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL rstp_vblank: got fs=%b done=%b, expected 0 0", front_sel, swap_done);
    end
    vblank = 1'b0; tick();
    do_read(7, 7);
    checks++;
    if (scan_color !== m0[7*W+7]) begin
      errors++;
      $display("FAIL rstp_write_drop: got %h, expected %h", scan_color, m0[7*W+7]);
    end
  endtask

  task automatic test_coincide();
    swap_req = 1'b1; vblank = 1'b1; tick();
    checks++;
    if (swap_pending !== 1'b1 || front_sel !== 1'b0 || swap_done !== 1'b0) begin
      errors++;
      $display("FAIL coincide_enter: got pend=%b fs=%b done=%b, expected 1 0 0",
               swap_pending, front_sel, swap_done);
    end
    swap_req = 1'b0; vblank = 1'b0; tick();
    vblank = 1'b1; tick();
    checks++;
    if (front_sel !== 1'b1 || swap_done !== 1'b1 || swap_pending !== 1'b0) begin
      errors++;
      $display("FAIL coincide_swap: got fs=%b done=%b pend=%b, expected 1 1 0",
               front_sel, swap_done, swap_pending);
    end
    exp_front = 1'b1;
    vblank = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1; fb_write = 1'b0; swap_req = 1'b0; vblank = 1'b0; scan_en = 1'b0;
    fb_x = '0; fb_y = '0; fb_color = '0; scan_x = '0; scan_y = '0;
    exp_front = 1'b0;
    for (int i = 0; i < N; i++) begin
      m0[i] = 16'h0;
      m1[i] = 16'h0;
    end
    test_reset();
    test_basic();
    test_fill_scan();
    test_out_of_range();
    test_double_req();
    test_toggle_cycle();
    test_reset_pending();
    test_coincide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer.md
FRAMEBUFFER -- requirements
Module: framebuffer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 400, visible framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 240, visible framebuffer height in pixels.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port fb_x  input  $clog2(FB_WIDTH)+1  GPU write x coordinate.
REQ-006 SHALL have port fb_y  input  $clog2(FB_HEIGHT)+1  GPU write y coordinate.
REQ-007 SHALL have port fb_color  input  16  GPU write colour, stored verbatim, including bit 0.
REQ-008 SHALL have port fb_write  input  1  write strobe, one pixel per cycle.
REQ-009 SHALL have port swap_req  input  1  level; rising edge requests a buffer swap.
REQ-010 SHALL have port vblank  input  1  display vertical-blank level; rising edge is the swap point.
REQ-011 SHALL have port scan_en  input  1  display read request.
REQ-012 SHALL have port scan_x  input  $clog2(FB_WIDTH)+1  display read x coordinate.
REQ-013 SHALL have port scan_y  input  $clog2(FB_HEIGHT)+1  display read y coordinate.
REQ-014 SHALL have port scan_color  output  16  display read data.
REQ-015 SHALL have port scan_valid  output  1  scan_color valid.
REQ-016 SHALL have port front_sel  output  1  index of the displayed bank; the other bank is the back bank.
REQ-017 SHALL have port swap_pending  output  1  high while a swap is waiting for vblank.
REQ-018 SHALL have port swap_done  output  1  one-cycle pulse in the cycle after the swap.

Function
REQ-019 SHALL hold two banks of FB_WIDTH*FB_HEIGHT 16-bit words.
REQ-020 SHALL address each bank word as y*FB_WIDTH+x.
REQ-021 SHALL accept a write when fb_write=1, fb_x<FB_WIDTH and fb_y<FB_HEIGHT, storing fb_color into the bank !front_sel at the next edge.
REQ-022 SHALL silently drop out-of-range writes, modifying no memory.
REQ-023 SHALL treat a scan_en read with scan_x<FB_WIDTH and scan_y<FB_HEIGHT at edge N as follows: front-bank data on scan_color and scan_valid=1 after edge N+1, i.e. 1-cycle latency.
REQ-024 SHALL respond to an out-of-range scan_en read with scan_color=0 and scan_valid=1 at the same latency.
REQ-025 SHALL drive scan_valid=0 in any cycle following scan_en=0; scan_color then holds its last value.
REQ-026 SHALL register swap_req and vblank and detect rising edges as old==0 && current==1.
REQ-027 SHALL implement swap FSM states IDLE, WAIT_VBLANK.
REQ-028 SHALL move IDLE->WAIT_VBLANK on a swap_req rising edge.
REQ-029 SHALL, in WAIT_VBLANK on a vblank rising edge, toggle front_sel, pulse swap_done, and return to IDLE.
REQ-030 SHALL ignore vblank edges in IDLE and swap_req edges in WAIT_VBLANK; no queuing.
REQ-031 SHALL set swap_pending=1 exactly in WAIT_VBLANK.
REQ-032 SHALL, when a swap_req edge and a vblank edge coincide in IDLE, enter WAIT_VBLANK only, swapping at the next vblank edge.
REQ-033 SHALL steer a write in the toggle cycle to the pre-toggle back bank, and serve a read in the toggle cycle from the pre-toggle front bank; bank selection uses registered front_sel.
REQ-034 SHALL let the write and read ports target different banks with no stall and no collision handling.

Reset
REQ-035 SHALL, on reset, set FSM=IDLE, front_sel=0, swap_pending=0, swap_done=0, scan_valid=0, scan_color=0, and edge-history registers=0.
REQ-036 SHALL not clear memory contents on reset.
REQ-037 SHALL, on reset in WAIT_VBLANK, abandon the swap (no toggle), and drop any write in the reset cycle.

Structure
REQ-038 SHALL take FB_WIDTH/FB_HEIGHT defaults, colour width 16, and FSM state encodings from shared package gfx_pkg.
REQ-039 SHALL instantiate sub-module fb_bram twice, once per bank: simple dual-port, one write and one registered read port, 1-cycle read latency.
REQ-040 SHALL compute the address multiply with constant FB_WIDTH in its own combinational path, mapped as shift-add by synthesis.

Verification
REQ-041 SHALL verify: after reset, write (10,20)=0xABCD, read (10,20) -> read returns 0 (front bank 0); swap_req edge, then vblank edge -> front_sel=1, swap_done pulse; read (10,20) -> 0xABCD after 1 cycle.
REQ-042 SHALL verify: write (400,5) and (5,240) -> no bank changes (full-memory compare); read (400,0) -> scan_color=0, scan_valid=1.
REQ-043 SHALL verify: swap_req edge, second swap_req edge, one vblank edge -> exactly one toggle; second vblank edge -> no toggle.
REQ-044 SHALL verify: a write in the toggle cycle lands in old back bank, now front; a read in the toggle cycle returns old front data.
REQ-045 SHALL verify: reset asserted while swap_pending=1 -> front_sel=0, swap_pending=0; a subsequent vblank edge causes no swap.
REQ-046 SHALL verify: back-to-back writes over all 96000 pixels at one per cycle, then swap and full scan -> all pixels read back correctly with no stalls.
